// File: rtl/rsa_rfid_pkg.sv
// Shared types and constants for the rsa_rfid modular-exponentiation core.
package rsa_rfid_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_CHECK,
        S_MUL,
        S_SQR,
        S_FINISH,
        S_DONE
    } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: product = a*b mod m in exactly WIDTH cycles.
// The start cycle performs the first iteration directly on the input operands.
module rsa_modmul
    import rsa_rfid_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] m_in;
    logic             bit_in;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] m_ext;

    always_comb begin
        r_in   = start ? '0 : r_q;
        bit_in = start ? a[WIDTH-1] : a_sh[WIDTH-1];
        b_in   = start ? b : b_q;
        m_in   = start ? m : m_q;
        m_ext  = {2'b00, m_in};
        acc    = ({2'b00, r_in} << 1) + (bit_in ? {2'b00, b_in} : '0);
        // r < m and b < m bound acc below 3m, so two conditional subtracts suffice
        if (acc >= m_ext) acc = acc - m_ext;
        if (acc >= m_ext) acc = acc - m_ext;
        product = acc[WIDTH-1:0];
    end

    assign busy  = (cnt != '0);
    assign ready = start ? (WIDTH == 1) : (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            b_q  <= '0;
            m_q  <= '0;
            r_q  <= '0;
            cnt  <= '0;
        end else if (start) begin
            a_sh <= a << 1;
            b_q  <= b;
            m_q  <= m;
            r_q  <= product;
            cnt  <= CW'(WIDTH - 1);
        end else if (cnt != '0) begin
            a_sh <= a_sh << 1;
            r_q  <= product;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/rsa_rfid.sv
// Right-to-left square-and-multiply modular exponentiation: output_text = input_text^key mod mod.
// Optional busy output enabled by defining RSA_RFID_BUSY_EN.
//
// state    | meaning
// IDLE     | waiting for go
// REDUCE   | base = input_text mod mod
// CHECK    | inspect exponent: finish, multiply or square
// MUL      | result = result * base mod mod
// SQR      | base = base * base mod mod, exponent shifted right
// FINISH   | publish result, raise done
// DONE     | hold result until the next go
module rsa_rfid
    import rsa_rfid_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] input_text,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] mod,
    output logic [WIDTH-1:0] output_text,
    output logic             done
`ifdef RSA_RFID_BUSY_EN
    ,
    output logic             busy
`endif
);

    state_t state, state_nxt;

    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] result_q;

    logic             mm_start;
    logic             mm_busy;
    logic             mm_ready;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_product;
    logic             in_mul_state;
    logic             run_busy;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                // mod < 2 routes through CHECK with a zero exponent, publishing 0
                if (go) state_nxt = (mod < WIDTH'(2)) ? S_CHECK : S_REDUCE;
            end
            S_REDUCE: if (mm_ready) state_nxt = S_CHECK;
            S_CHECK: begin
                if (exp_q == '0)  state_nxt = S_FINISH;
                else if (exp_q[0]) state_nxt = S_MUL;
                else               state_nxt = S_SQR;
            end
            S_MUL:    if (mm_ready) state_nxt = S_SQR;
            S_SQR:    if (mm_ready) state_nxt = S_CHECK;
            S_FINISH: state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_mul_state = (state == S_REDUCE) || (state == S_MUL) || (state == S_SQR);
        mm_start     = in_mul_state && !mm_busy;
        run_busy     = (state != S_IDLE) && (state != S_DONE);
        mm_a         = '0;
        mm_b         = '0;
        case (state)
            S_REDUCE: begin
                mm_a = in_q;
                mm_b = WIDTH'(1);
            end
            S_MUL: begin
                mm_a = result_q;
                mm_b = base_q;
            end
            S_SQR: begin
                mm_a = base_q;
                mm_b = base_q;
            end
            default: ;
        endcase
    end

`ifdef RSA_RFID_BUSY_EN
    assign busy = run_busy;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q        <= '0;
            mod_q       <= '0;
            exp_q       <= '0;
            base_q      <= '0;
            result_q    <= '0;
            output_text <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        in_q  <= input_text;
                        mod_q <= mod;
                        done  <= 1'b0;
                        if (mod < WIDTH'(2)) begin
                            result_q <= '0;
                            exp_q    <= '0;
                        end else begin
                            result_q <= WIDTH'(1);
                            exp_q    <= key;
                        end
                    end
                end
                S_REDUCE: if (mm_ready) base_q <= mm_product;
                S_MUL:    if (mm_ready) result_q <= mm_product;
                S_SQR: begin
                    if (mm_ready) begin
                        base_q <= mm_product;
                        exp_q  <= exp_q >> 1;
                    end
                end
                S_FINISH: begin
                    output_text <= result_q;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk     (clk),
        .reset   (reset),
        .start   (mm_start),
        .a       (mm_a),
        .b       (mm_b),
        .m       (mod_q),
        .busy    (mm_busy),
        .ready   (mm_ready),
        .product (mm_product)
    );

endmodule

// File: tb/tb_rsa_rfid.sv
// Directed bench for rsa_rfid: hand-computed results and done latencies, restart, ignored go, mid-run reset.
module tb_rsa_rfid;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             go;
    logic [WIDTH-1:0] input_text;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] mod;
    logic [WIDTH-1:0] output_text;
    logic             done;
`ifdef RSA_RFID_BUSY_EN
    logic             busy;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [WIDTH-1:0] last_result = '0;

    rsa_rfid #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .input_text  (input_text),
        .key         (key),
        .mod         (mod),
        .output_text (output_text),
        .done        (done)
`ifdef RSA_RFID_BUSY_EN
        ,
        .busy        (busy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Applies go for one edge (edge 0), then scrambles the operand inputs.
    task automatic start_op(input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] k,
                            input logic [WIDTH-1:0] m);
        @(negedge clk);
        input_text = i;
        key        = k;
        mod        = m;
        go         = 1'b1;
        @(posedge clk);
        #1;
        go         = 1'b0;
        input_text = 8'hAA;
        key        = 8'h55;
        mod        = 8'h33;
    endtask

    task automatic wait_done(output int cyc);
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] k,
                          input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp_out,
                          input int exp_lat);
        int cyc;
        start_op(i, k, m);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_held"}, output_text, last_result);
`ifdef RSA_RFID_BUSY_EN
        check({tag, "_busy_hi"}, busy, 1);
`endif
        wait_done(cyc);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_out"}, output_text, exp_out);
`ifdef RSA_RFID_BUSY_EN
        check({tag, "_busy_lo"}, busy, 0);
`endif
        last_result = exp_out;
    endtask

    initial begin
        int cyc;
        reset      = 1'b1;
        go         = 1'b0;
        input_text = '0;
        key        = '0;
        mod        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_out", output_text, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("k1",     8'd5,   8'h01,  8'hFD,  8'd5, 27);
        run_op("k3",     8'd5,   8'd3,   8'd13,  8'd8, 44);
        run_op("k2",     8'd20,  8'd2,   8'd7,   8'd1, 36);
        run_op("k200",   8'd3,   8'd200, 8'd7,   8'd2, 106);
        run_op("k0",     8'd9,   8'd0,   8'd11,  8'd1, 10);
        run_op("zz",     8'd0,   8'd0,   8'd5,   8'd1, 10);
        run_op("m0",     8'd7,   8'd5,   8'd0,   8'd0, 2);
        run_op("m1",     8'd7,   8'd5,   8'd1,   8'd0, 2);
        run_op("k255",   8'd255, 8'd255, 8'd254, 8'd1, 146);

        repeat (3) @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_out", output_text, 1);

        // go during a run must be ignored
        start_op(8'd5, 8'd3, 8'd13);
        repeat (15) @(posedge clk);
        @(negedge clk);
        input_text = 8'd20;
        key        = 8'd2;
        mod        = 8'd7;
        go         = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        wait_done(cyc);
        check("busy_go_lat", 16 + cyc, 44);
        check("busy_go_out", output_text, 8);
        last_result = 8'd8;

        // reset mid-run
        start_op(8'd3, 8'd200, 8'd7);
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_done", done, 0);
        check("mrst_out", output_text, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mrst_idle", done, 0);
        last_result = '0;
        run_op("after_rst", 8'd3, 8'd200, 8'd7, 8'd2, 106);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
